// File: rtl/bp_sweep_pkg.sv
// Shared types and default widths for the band-pass bench sweep scheduler.
package bp_sweep_pkg;

  localparam int unsigned FW_DEF = 32;
  localparam int unsigned NW_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DC   = 2'd1,
    AC   = 2'd2,
    NEXT = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/sweep_freq_step.sv
// Next-frequency computation with carry-out overflow detect.
// SWEEP_LOG_EN selects the geometric step (f + (f >> f_shift)) instead of f + f_step.
module sweep_freq_step #(
  parameter int unsigned FW = 32
) (
  input  logic [FW-1:0] ac_freq,
  input  logic [FW-1:0] f_step,
`ifdef SWEEP_LOG_EN
  input  logic [4:0]    f_shift,
`endif
  output logic [FW-1:0] f_next,
  output logic          ovf
);

  logic [FW-1:0] incr;
  logic [FW:0]   sum;

`ifdef SWEEP_LOG_EN
  assign incr = ac_freq >> f_shift;
`else
  assign incr = f_step;
`endif

  assign sum = {1'b0, ac_freq} + {1'b0, incr};
  assign {ovf, f_next} = sum;

endmodule

// File: rtl/bp_sweep_sched.sv
// Sweep scheduler: one DC operating-point request, then n_points AC requests over req/ack.
// Optional SWEEP_LOG_EN adds the f_shift port and uses a geometric frequency step.
module bp_sweep_sched
  import bp_sweep_pkg::*;
#(
  parameter int unsigned FW = FW_DEF,
  parameter int unsigned NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_step,
`ifdef SWEEP_LOG_EN
  input  logic [4:0]    f_shift,
`endif
  input  logic [NW-1:0] n_points,
  output logic          dc_req,
  input  logic          dc_ack,
  output logic          ac_req,
  input  logic          ac_ack,
  output logic [FW-1:0] ac_freq,
  output logic [NW-1:0] ac_index,
  output logic          busy,
  output logic          done,
  output logic          err
);

  sweep_state_e  state, state_n;
  logic [FW-1:0] f_start_q, f_step_q;
  logic [NW-1:0] n_q;
  logic [FW-1:0] f_next;
  logic          ovf;
  logic          latch_en, load_first, load_next, fin, set_err;

`ifdef SWEEP_LOG_EN
  logic [4:0] f_shift_q;
`endif

  sweep_freq_step #(.FW(FW)) u_step (
    .ac_freq (ac_freq),
    .f_step  (f_step_q),
`ifdef SWEEP_LOG_EN
    .f_shift (f_shift_q),
`endif
    .f_next  (f_next),
    .ovf     (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Abort is checked ahead of each ack so it always wins a same-cycle ack.
  always_comb begin
    state_n    = state;
    dc_req     = 1'b0;
    ac_req     = 1'b0;
    busy       = 1'b1;
    latch_en   = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;
    fin        = 1'b0;
    set_err    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          latch_en = 1'b1;
          state_n  = DC;
        end
      end
      DC: begin
        dc_req = 1'b1;
        if (abort) begin
          state_n = IDLE;
        end else if (dc_ack) begin
          if (n_q == '0) begin
            fin     = 1'b1;
            state_n = IDLE;
          end else begin
            load_first = 1'b1;
            state_n    = AC;
          end
        end
      end
      AC: begin
        ac_req = 1'b1;
        if (abort) begin
          state_n = IDLE;
        end else if (ac_ack) begin
          if (ac_index == n_q - NW'(1)) begin
            fin     = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = NEXT;
          end
        end
      end
      NEXT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (ovf) begin
          set_err = 1'b1;
          fin     = 1'b1;
          state_n = IDLE;
        end else begin
          load_next = 1'b1;
          state_n   = AC;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_start_q <= '0;
      f_step_q  <= '0;
      n_q       <= '0;
      ac_freq   <= '0;
      ac_index  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef SWEEP_LOG_EN
      f_shift_q <= '0;
`endif
    end else begin
      done <= fin;
      if (latch_en) begin
        f_start_q <= f_start;
        f_step_q  <= f_step;
        n_q       <= n_points;
        err       <= 1'b0;
`ifdef SWEEP_LOG_EN
        f_shift_q <= f_shift;
`endif
      end
      if (set_err) err <= 1'b1;
      if (load_first) begin
        ac_freq  <= f_start_q;
        ac_index <= '0;
      end
      if (load_next) begin
        ac_freq  <= f_next;
        ac_index <= ac_index + NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bp_sweep_sched.sv
// Directed self-checking bench for bp_sweep_sched (linear build; log test when SWEEP_LOG_EN is defined).
module tb_bp_sweep_sched;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] f_start, f_step;
  logic [4:0]  f_shift;
  logic [9:0]  n_points;
  logic        dc_req, dc_ack, ac_req, ac_ack;
  logic [31:0] ac_freq;
  logic [9:0]  ac_index;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  // Results captured by the engine model for the most recent sweep.
  logic [31:0] rec_freq [16];
  logic [9:0]  rec_idx  [16];
  int          rec_n, dc_cnt, done_cnt, ac_high, done_cyc, dc_ack_cyc, ac_ack_cyc;
  logic        err_at_done, busy_at_done, overlap, launch_ok;

  always #5 clk = ~clk;

  bp_sweep_sched #(.FW(32), .NW(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .f_start  (f_start),
    .f_step   (f_step),
`ifdef SWEEP_LOG_EN
    .f_shift  (f_shift),
`endif
    .n_points (n_points),
    .dc_req   (dc_req),
    .dc_ack   (dc_ack),
    .ac_req   (ac_req),
    .ac_ack   (ac_ack),
    .ac_freq  (ac_freq),
    .ac_index (ac_index),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches a sweep and plays the analysis engine until done (bounded).
  task automatic engine(input logic [31:0] fs, input logic [31:0] step, input logic [9:0] n,
                        input int lat, input bit hold, input bit mid_start);
    int   cyc, cnt;
    logic prev_dc, prev_ac;
    f_start = fs; f_step = step; n_points = n; start = 1'b1;
    tick();
    start = 1'b0;
    f_start = 32'hDEAD_BEEF; f_step = 32'd3; n_points = 10'd9;
    launch_ok = busy && dc_req;
    rec_n = 0; dc_cnt = 0; done_cnt = 0; ac_high = 0; overlap = 1'b0;
    done_cyc = -1; dc_ack_cyc = -100; ac_ack_cyc = -100;
    err_at_done = 1'b0; busy_at_done = 1'b1;
    cyc = 0; cnt = 0; prev_dc = 1'b0; prev_ac = 1'b0;
    while (cyc < 300) begin
      if (dc_req && ac_req) overlap = 1'b1;
      if (dc_req && !prev_dc) dc_cnt++;
      if (ac_req && !prev_ac && rec_n < 16) begin
        rec_freq[rec_n] = ac_freq;
        rec_idx[rec_n]  = ac_index;
        rec_n++;
      end
      if (ac_req) ac_high++;
      if (done) begin
        done_cnt++;
        err_at_done  = err;
        busy_at_done = busy;
        done_cyc     = cyc;
        break;
      end
      prev_dc = dc_req;
      prev_ac = ac_req;
      start = (mid_start && cyc == 6);
      if (hold) begin
        dc_ack = 1'b1;
        ac_ack = 1'b1;
        if (dc_req) dc_ack_cyc = cyc;
        if (ac_req) ac_ack_cyc = cyc;
      end else if (dc_req || ac_req) begin
        dc_ack = dc_req && (cnt == lat);
        ac_ack = ac_req && (cnt == lat);
        if (dc_ack) dc_ack_cyc = cyc;
        if (ac_ack) ac_ack_cyc = cyc;
        cnt = (cnt == lat) ? 0 : cnt + 1;
      end else begin
        dc_ack = 1'b0;
        ac_ack = 1'b0;
        cnt    = 0;
      end
      tick();
      cyc++;
    end
    dc_ack = 1'b0;
    ac_ack = 1'b0;
    start  = 1'b0;
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL engine_done_timeout: done pulses %0d, required 1", done_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({dc_req, ac_req, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000", {dc_req, ac_req, busy, done, err});
    end
    checks++;
    if (ac_freq !== 32'd0 || ac_index !== 10'd0) begin
      errors++;
      $display("FAIL reset_point: freq %0h idx %0d required 0 0", ac_freq, ac_index);
    end
  endtask

  task automatic test_linear();
    engine(32'd1000, 32'd500, 10'd4, 3, 1'b0, 1'b0);
    checks++;
    if (!launch_ok) begin errors++; $display("FAIL lin_launch: busy/dc_req not high after start"); end
    checks++;
    if (dc_cnt !== 1 || rec_n !== 4) begin
      errors++; $display("FAIL lin_counts: dc %0d ac %0d required 1 4", dc_cnt, rec_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rec_freq[i] !== 32'd1000 + 32'(i) * 32'd500 || rec_idx[i] !== 10'(i)) begin
        errors++;
        $display("FAIL lin_point%0d: freq %0d idx %0d required %0d %0d",
                 i, rec_freq[i], rec_idx[i], 1000 + i * 500, i);
      end
    end
    checks++;
    if (ac_high !== 16) begin errors++; $display("FAIL lin_req_cycles: got %0d required 16", ac_high); end
    checks++;
    if (done_cyc !== ac_ack_cyc + 1 || busy_at_done !== 1'b0 || ac_req !== 1'b0) begin
      errors++;
      $display("FAIL lin_done_timing: done_cyc %0d ack_cyc %0d busy %b ac_req %b",
               done_cyc, ac_ack_cyc, busy_at_done, ac_req);
    end
    checks++;
    if (err_at_done !== 1'b0 || overlap) begin
      errors++; $display("FAIL lin_err_overlap: err %b overlap %b required 0 0", err_at_done, overlap);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL lin_done_pulse: done %b required 0", done); end
  endtask

  task automatic test_zero_points();
    engine(32'd77, 32'd1, 10'd0, 2, 1'b0, 1'b0);
    checks++;
    if (rec_n !== 0 || dc_cnt !== 1) begin
      errors++; $display("FAIL zero_counts: ac %0d dc %0d required 0 1", rec_n, dc_cnt);
    end
    checks++;
    if (done_cyc !== dc_ack_cyc + 1) begin
      errors++; $display("FAIL zero_done_timing: done %0d dc_ack %0d", done_cyc, dc_ack_cyc);
    end
  endtask

  task automatic test_overflow();
    engine(32'hFFFF_FF00, 32'h200, 10'd5, 1, 1'b0, 1'b0);
    checks++;
    if (rec_n !== 1 || rec_freq[0] !== 32'hFFFF_FF00) begin
      errors++; $display("FAIL ovf_points: n %0d freq %0h required 1 ffffff00", rec_n, rec_freq[0]);
    end
    checks++;
    if (err_at_done !== 1'b1 || done_cyc !== ac_ack_cyc + 2) begin
      errors++; $display("FAIL ovf_err: err %b done %0d ack %0d", err_at_done, done_cyc, ac_ack_cyc);
    end
    tick();
    checks++;
    if (ac_req !== 1'b0 || err !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL ovf_after: ac_req %b err %b done %b required 0 1 0", ac_req, err, done);
    end
  endtask

  task automatic test_abort();
    int i;
    f_start = 32'd100; f_step = 32'd10; n_points = 10'd4;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || dc_req !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL start_beats_abort: busy %b dc_req %b err %b", busy, dc_req, err);
    end
    for (i = 0; i < 50 && !(ac_req && ac_index == 10'd1); i++) begin
      dc_ack = dc_req;
      ac_ack = ac_req;
      tick();
    end
    dc_ack = 1'b0; ac_ack = 1'b0;
    checks++;
    if (ac_freq !== 32'd110 || ac_index !== 10'd1) begin
      errors++; $display("FAIL abort_reach_p1: freq %0d idx %0d required 110 1", ac_freq, ac_index);
    end
    ac_ack = 1'b1; abort = 1'b1;
    tick();
    ac_ack = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, dc_req, ac_req, done, err} !== 5'b0) begin
      errors++; $display("FAIL abort_idle: got %b required 00000", {busy, dc_req, ac_req, done, err});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: done %b busy %b required 0 0", done, busy);
    end
    engine(32'd200, 32'd25, 10'd3, 1, 1'b0, 1'b0);
    checks++;
    if (dc_cnt !== 1 || rec_n !== 3 || rec_freq[0] !== 32'd200 || rec_freq[2] !== 32'd250) begin
      errors++;
      $display("FAIL abort_rerun: dc %0d n %0d f0 %0d f2 %0d required 1 3 200 250",
               dc_cnt, rec_n, rec_freq[0], rec_freq[2]);
    end
  endtask

  task automatic test_back_to_back();
    engine(32'd10, 32'd0, 10'd2, 0, 1'b1, 1'b0);
    checks++;
    if (rec_n !== 2 || ac_high !== 2 || rec_freq[1] !== 32'd10 || rec_idx[1] !== 10'd1) begin
      errors++;
      $display("FAIL hold_ack: n %0d high %0d f1 %0d idx1 %0d required 2 2 10 1",
               rec_n, ac_high, rec_freq[1], rec_idx[1]);
    end
    // Relaunch straight from the done cycle.
    engine(32'd5000, 32'd1, 10'd3, 2, 1'b0, 1'b1);
    checks++;
    if (!launch_ok || dc_cnt !== 1 || rec_n !== 3 || rec_freq[2] !== 32'd5002) begin
      errors++;
      $display("FAIL b2b_midstart: launch %b dc %0d n %0d f2 %0d required 1 1 3 5002",
               launch_ok, dc_cnt, rec_n, rec_freq[2]);
    end
  endtask

  task automatic test_reset_mid();
    int i;
    f_start = 32'd300; f_step = 32'd7; n_points = 10'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (i = 0; i < 50 && !(ac_req && ac_index == 10'd1); i++) begin
      dc_ack = dc_req;
      ac_ack = ac_req;
      tick();
    end
    dc_ack = 1'b0; ac_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({dc_req, ac_req, busy, done, err} !== 5'b0 || ac_freq !== 32'd0 || ac_index !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid: flags %b freq %0d idx %0d required 00000 0 0",
               {dc_req, ac_req, busy, done, err}, ac_freq, ac_index);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_quiet: done %b busy %b required 0 0", done, busy);
    end
  endtask

`ifdef SWEEP_LOG_EN
  task automatic test_log();
    f_shift = 5'd1;
    engine(32'd1024, 32'd999, 10'd3, 2, 1'b0, 1'b0);
    checks++;
    if (rec_n !== 3 || rec_freq[0] !== 32'd1024 || rec_freq[1] !== 32'd1536 || rec_freq[2] !== 32'd2304) begin
      errors++;
      $display("FAIL log_points: n %0d %0d %0d %0d required 3 1024 1536 2304",
               rec_n, rec_freq[0], rec_freq[1], rec_freq[2]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; dc_ack = 1'b0; ac_ack = 1'b0;
    f_start = '0; f_step = '0; f_shift = 5'd0; n_points = '0;
    test_reset();
    test_linear();
    test_zero_points();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef SWEEP_LOG_EN
    test_log();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_sweep_sched.md
# bp_sweep_sched

Sweep scheduler for the active band-pass filter bench: sequences one DC operating-point request to the analysis engine, then N AC frequency points for the Vac source, one at a time over a req/ack handshake. Holds the frequency word and point index stable for each AC request. Sits between the bench control registers and the analysis engine that drives V1 and samples the filter output.

## Interface

Parameters:
- FW, 32: frequency word width (Hz, unsigned integer)
- NW, 10: point-count / index width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle sweep launch; sampled only in IDLE
- abort  in  1  cancel the sweep; return to IDLE
- f_start  in  FW  first AC frequency; sampled on accepted start
- f_step  in  FW  linear increment; sampled on accepted start
- f_shift  in  5  log step shift; present only with SWEEP_LOG_EN
- n_points  in  NW  number of AC points; sampled on accepted start
- dc_req  out  1  DC operating-point request
- dc_ack  in  1  DC done
- ac_req  out  1  AC point request
- ac_ack  in  1  AC point done
- ac_freq  out  FW  frequency of the current AC point
- ac_index  out  NW  index of the current AC point, 0-based
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at normal or overflow completion
- err  out  1  sticky frequency overflow flag; cleared on the next accepted start

## Operation

- States: IDLE, DC, AC, NEXT.
- IDLE: when start=1, latch the inputs, clear err, and go to DC. Otherwise stay in IDLE.
- DC: dc_req=1. When dc_ack=1: if n_points=0, pulse done and go to IDLE. Otherwise go to AC with ac_freq=f_start and ac_index=0.
- AC: ac_req=1. When ac_ack=1:
  - If ac_index=n_points-1: pulse done and go to IDLE.
  - Otherwise go to NEXT.
- NEXT: ac_req=0. Compute f_next.
  - Linear: f_next = ac_freq + f_step.
  - Log (SWEEP_LOG_EN): f_next = ac_freq + (ac_freq >> f_shift).
  - The sum is FW+1 bits wide. If the carry out is 1: set err, pulse done, go to IDLE.
  - Otherwise load ac_freq=f_next, increment ac_index, and go to AC.
- Handshake rules:
  - A req stays high until the cycle its ack is sampled high.
  - The req is low in the following cycle.
  - An ack while its req is low is ignored.
  - dc_req and ac_req are never high together.
- Outputs: busy=1 in every state except IDLE. ac_freq and ac_index change only on entry to AC.
- Abort:
  - In any non-IDLE state, abort=1 forces IDLE on the next edge.
  - Both reqs drop, no done pulse, and err keeps its value.
  - abort has priority over a simultaneous ack.
  - abort in IDLE has no effect.
- start while busy is ignored. start and abort together in IDLE: start wins.
- Reset values: state IDLE; dc_req, ac_req, busy, done, err all 0; ac_freq 0; ac_index 0.
- A reset mid-sweep abandons the sweep with no done pulse.

## Timing

- start sampled at edge t: busy=1 and dc_req=1 from cycle t+1.
- dc_ack sampled at edge k: from cycle k+1, dc_req=0, ac_req=1 and ac_freq=f_start.
- ac_ack sampled at edge m on a non-final point:
  - cycle m+1: ac_req=0 (NEXT)
  - cycle m+2: ac_req=1 with the new ac_freq and ac_index
  - Point-to-point overhead: 2 cycles plus the engine latency.
- Final ac_ack at edge m: in cycle m+1, done=1, busy=0 and ac_req=0.
- Overflow detected in NEXT at edge m+1: done=1 and err=1 in cycle m+2, with no further ac_req.
- The earliest new start is accepted in the cycle done is high, since the block is already in IDLE.

## Configuration

- SWEEP_LOG_EN defined:
  - The f_shift port exists and the geometric step is used.
  - f_step is still a port but is ignored.
  - f_shift=0 doubles the frequency on each point.
- SWEEP_LOG_EN undefined:
  - There is no f_shift port and the step is linear using f_step.
  - f_step=0 repeats the same frequency for all points.

## Structure

- Package bp_sweep_pkg holds:
  - the state enum (IDLE, DC, AC, NEXT)
  - default FW and NW constants
- Sub-module sweep_freq_step:
  - Combinational; inputs ac_freq, f_step and f_shift.
  - Outputs f_next[FW-1:0] and ovf.
  - Contains the SWEEP_LOG_EN selection so the FSM is mode-agnostic.

## Test plan

- Linear sweep: f_start=1000, f_step=500, n_points=4, ack 3 cycles after each req. Required: one dc_req, then ac_freq 1000, 1500, 2000, 2500 with ac_index 0..3, then one done pulse; err=0.
- n_points=0: start, then dc_ack. Required: done in the cycle after dc_ack, and ac_req never asserted.
- Overflow with FW=32: f_start=0xFFFF_FF00, f_step=0x200, n_points=5. Required: one AC point at 0xFFFF_FF00, then done=1 and err=1, with no second ac_req.
- Abort in the AC state coinciding with ac_ack on point 1. Required: IDLE next cycle, reqs low, no done pulse; a following start clears err and re-runs from DC.
- With SWEEP_LOG_EN: f_start=1024, f_shift=1, n_points=3. Required: ac_freq 1024, 1536, 2304.
- Protocol checks: start pulsed mid-sweep is ignored; an ack held high continuously gives exactly one transaction per req with a 1-cycle req gap; rst asserted mid-sweep returns all outputs to their reset values next cycle.
